// File: rtl/uart_srx_driver.sv
// ---------------------------------------------------------------------------
// uart_srx_driver
//
// 8N1 UART transmitter that drives the SoC uart_srx input. Bytes enter a
// small circular FIFO over a valid/ready handshake and are serialized
// LSB-first (start bit, 8 data bits, stop bit) at a fixed baud divisor.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   tx_data     byte to transmit
//   tx_valid    tx_data is valid this cycle
//   tx_ready    FIFO can accept a byte this cycle
//   uart_srx    serial line to the SoC, idle high, registered
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes queued, excluding the byte being shifted
//   frame_done  one-cycle pulse on the last cycle of each stop bit
// ---------------------------------------------------------------------------
module uart_srx_driver #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_srx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             frame_done
);

    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST  = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push;
    logic             pop;
    logic             baud_end;

    assign tx_ready = (fifo_count != FULL_COUNT);
    assign push     = tx_valid && tx_ready;
    assign baud_end = (baud_cnt == BAUD_LAST);

    // A pop happens whenever the shifter wants a new byte: straight away
    // from IDLE, or on the final stop-bit cycle so frames run back-to-back.
    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) || ((state == STOP) && baud_end));

    // Byte storage; contents need no reset because the pointers and count
    // define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two. A push
    // and a pop in the same cycle both move their pointers, count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Serializer FSM. The line, frame_done and busy are registered from the
    // current state, so they trail the state by one cycle: the start bit
    // appears on the edge after the pop, and frame_done lines up with the
    // last cycle of the stop bit as seen on the wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            uart_srx   <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                START:   uart_srx <= 1'b0;
                DATA:    uart_srx <= shift[0];
                default: uart_srx <= 1'b1;
            endcase
            frame_done <= (state == STOP) && baud_end;
            busy       <= (state != IDLE) || (fifo_count != '0);

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
